// File: rtl/pill_feeder.sv
// pill_feeder: paces pill dispensing, counts pills per bottle in BCD and holds a
// timed bottle-swap window between bottles until the counter bank reports finished.
module pill_feeder #(
    parameter int TICK_DIV   = 50000,
    parameter int SWAP_TICKS = 500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       pause,
    input  logic       finished,
    input  logic [7:0] gap_setting,
    input  logic [7:0] pill_setting,
    output logic       pill_pulse,
    output logic       bottle_swap,
    output logic       done,
    output logic [7:0] in_bottle
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SWAP_TICKS + 1);

    typedef enum logic [1:0] {IDLE, FEED, SWAP, DONE} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [7:0]    gap;
    logic [SW-1:0] swap_cnt;
    logic          tick, pill_ok, gap_due, swap_last;
    logic [7:0]    gap_max, bcd_next;
    logic [3:0]    lo_next, hi_next;

    always_comb begin
        tick      = presc == PW'(TICK_DIV - 1);
        gap_max   = gap_setting == 8'd0 ? 8'd1 : gap_setting;
        gap_due   = {1'b0, gap} + 9'd1 >= {1'b0, gap_max};
        pill_ok   = pill_setting[7:4] <= 4'd9 && pill_setting[3:0] <= 4'd9 && pill_setting != 8'd0;
        lo_next   = in_bottle[3:0] == 4'd9 ? 4'd0 : in_bottle[3:0] + 4'd1;
        hi_next   = in_bottle[3:0] != 4'd9 ? in_bottle[7:4] : in_bottle[7:4] == 4'd9 ? 4'd0 : in_bottle[7:4] + 4'd1;
        bcd_next  = {hi_next, lo_next};
        swap_last = 32'(swap_cnt) + 32'd1 >= SWAP_TICKS;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            presc       <= '0;
            gap         <= '0;
            swap_cnt    <= '0;
            in_bottle   <= '0;
            pill_pulse  <= 1'b0;
            bottle_swap <= 1'b0;
            done        <= 1'b0;
        end else begin
            pill_pulse <= 1'b0;
            if (!en) begin
                state       <= IDLE;
                presc       <= '0;
                gap         <= '0;
                swap_cnt    <= '0;
                in_bottle   <= '0;
                bottle_swap <= 1'b0;
                done        <= 1'b0;
            end else if (state == IDLE) begin
                state <= FEED;
                presc <= '0;
                gap   <= '0;
            end else if (state == DONE) begin
                done <= 1'b1;
            end else if (finished) begin
                // a pulse due on this edge is deliberately dropped
                state       <= DONE;
                done        <= 1'b1;
                bottle_swap <= 1'b0;
                presc       <= '0;
                gap         <= '0;
                swap_cnt    <= '0;
            end else if (!pause) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick && state == FEED) begin
                    if (!gap_due) begin
                        gap <= gap + 8'd1;
                    end else if (!pill_ok) begin
                        gap <= gap_max;
                    end else begin
                        pill_pulse <= 1'b1;
                        gap        <= '0;
                        if (bcd_next == pill_setting) begin
                            in_bottle   <= '0;
                            state       <= SWAP;
                            bottle_swap <= 1'b1;
                            presc       <= '0;
                            swap_cnt    <= '0;
                        end else begin
                            in_bottle <= bcd_next;
                        end
                    end
                end else if (tick) begin
                    if (swap_last) begin
                        state       <= FEED;
                        bottle_swap <= 1'b0;
                        swap_cnt    <= '0;
                        gap         <= '0;
                        presc       <= '0;
                    end else begin
                        swap_cnt <= swap_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pill_feeder.sv
// tb_pill_feeder: directed checks of pill_feeder with TICK_DIV=4, SWAP_TICKS=3.
module tb_pill_feeder;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       pause = 1'b0;
    logic       finished = 1'b0;
    logic [7:0] gap_setting = 8'd2;
    logic [7:0] pill_setting = 8'h03;
    logic       pill_pulse, bottle_swap, done;
    logic [7:0] in_bottle;
    int         total = 0;
    int         bad = 0;
    int         pulses;

    pill_feeder #(.TICK_DIV(4), .SWAP_TICKS(3)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .pause(pause), .finished(finished),
        .gap_setting(gap_setting), .pill_setting(pill_setting),
        .pill_pulse(pill_pulse), .bottle_swap(bottle_swap), .done(done), .in_bottle(in_bottle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(2);
        check("reset_outputs", {21'd0, pill_pulse, bottle_swap, done, in_bottle}, 0);
        reset_n = 1'b1;
        cyc(1);
        en = 1'b1;
        cyc(8);
        check("no_pulse_e8", pill_pulse, 0);
        cyc(1);
        check("pulse_e9", pill_pulse, 1);
        check("in_bottle_e9", in_bottle, 8'h01);
        cyc(1);
        check("pulse_one_cycle", pill_pulse, 0);
        cyc(7);
        check("pulse_e17", pill_pulse, 1);
        check("in_bottle_e17", in_bottle, 8'h02);
        cyc(8);
        check("pulse_e25", pill_pulse, 1);
        check("swap_e25", bottle_swap, 1);
        check("in_bottle_clr_e25", in_bottle, 8'h00);
        cyc(11);
        check("swap_e36", bottle_swap, 1);
        cyc(1);
        check("swap_end_e37", bottle_swap, 0);
        cyc(7);
        check("no_pulse_e44", pill_pulse, 0);
        cyc(1);
        check("pulse_e45", pill_pulse, 1);
        cyc(1);
        pause = 1'b1;
        cyc(10);
        pause = 1'b0;
        check("pause_hold_in_bottle", in_bottle, 8'h01);
        cyc(6);
        check("no_pulse_paused_e62", pill_pulse, 0);
        cyc(1);
        check("pulse_delayed_e63", pill_pulse, 1);
        check("in_bottle_e63", in_bottle, 8'h02);
        cyc(7);
        finished = 1'b1;
        cyc(1);
        check("finish_no_pulse", pill_pulse, 0);
        check("finish_done", done, 1);
        check("finish_in_bottle", in_bottle, 8'h02);
        finished = 1'b0;
        en = 1'b0;
        cyc(1);
        check("idle_done_clr", done, 0);
        check("idle_in_bottle", in_bottle, 8'h00);
        pill_setting = 8'h01;
        en = 1'b1;
        cyc(9);
        check("single_pill_swap", bottle_swap, 1);
        check("single_pill_pulse", pill_pulse, 1);
        cyc(2);
        en = 1'b0;
        cyc(1);
        check("en_off_swap_clr", bottle_swap, 0);
        pill_setting = 8'h03;
        en = 1'b1;
        cyc(8);
        check("restart_no_pulse", pill_pulse, 0);
        check("restart_in_bottle", in_bottle, 8'h00);
        cyc(1);
        check("restart_pulse", pill_pulse, 1);
        check("restart_count", in_bottle, 8'h01);
        pill_setting = 8'h00;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            pulses += int'(pill_pulse);
        end
        check("zero_setting_pulses", pulses, 0);
        pill_setting = 8'h02;
        cyc(3);
        check("valid_wait_pulse", pill_pulse, 0);
        cyc(1);
        check("valid_next_tick", pill_pulse, 1);
        check("valid_swap", bottle_swap, 1);
        cyc(21);
        check("after_swap_count", in_bottle, 8'h01);
        check("after_swap_flag", bottle_swap, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset", {21'd0, pill_pulse, bottle_swap, done, in_bottle}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
